// File: rtl/voice_pwm_dac_if.sv
// voice_pwm_dac_if: control/status bundle between the voice adder side and the PWM DAC
interface voice_pwm_dac_if #(parameter int SUM_W = 4);
    logic             en;
    logic [SUM_W-1:0] sum_in;
    logic             clip_clr;
    logic             pwm_out;
    logic             period_start;
    logic             busy;
    logic             clip_flag;
    modport master (output en, sum_in, clip_clr, input pwm_out, period_start, busy, clip_flag);
    modport slave  (input en, sum_in, clip_clr, output pwm_out, period_start, busy, clip_flag);
endinterface

// File: rtl/voice_pwm_dac.sv
// voice_pwm_dac: converts the summed voice count into a per-period PWM audio bit
module voice_pwm_dac #(
    parameter int SUM_W    = 4,
    parameter int MAX_SUM  = 5,
    parameter int PRESCALE = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    voice_pwm_dac_if.slave bus
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int SW = $clog2(MAX_SUM + 1);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    state_t        r_state, w_state;
    logic [PW-1:0] r_pre, w_pre;
    logic [SW-1:0] r_step, w_step, r_duty, w_duty, w_clamp;
    logic          r_pwm, r_ps, r_clip, w_ps, w_latch, w_over, w_tick, w_bound;
    assign w_over  = bus.sum_in > SUM_W'(MAX_SUM);
    assign w_clamp = w_over ? SW'(MAX_SUM) : SW'(bus.sum_in);
    assign w_tick  = r_pre == PW'(PRESCALE - 1);
    assign w_bound = w_tick && (r_step == SW'(MAX_SUM - 1));
    always_comb begin
        w_state = r_state;
        w_pre   = r_pre;
        w_step  = r_step;
        w_duty  = r_duty;
        w_ps    = 1'b0;
        w_latch = 1'b0;
        if (r_state == IDLE) begin
            if (bus.en) begin
                w_state = RUN;
                w_latch = 1'b1;
            end
        end else begin
            w_pre   = w_tick ? '0 : r_pre + 1'b1;
            w_step  = w_tick ? ((r_step == SW'(MAX_SUM - 1)) ? '0 : r_step + 1'b1) : r_step;
            w_state = bus.en ? RUN : DRAIN;
            // a draining period that sees en again resumes as a normal boundary
            if (w_bound) begin
                if (r_state == RUN || bus.en) begin
                    w_latch = 1'b1;
                end else begin
                    w_state = IDLE;
                    w_duty  = '0;
                end
            end
        end
        if (w_latch) begin
            w_duty = w_clamp;
            w_ps   = 1'b1;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_pre   <= '0;
            r_step  <= '0;
            r_duty  <= '0;
            r_pwm   <= 1'b0;
            r_ps    <= 1'b0;
            r_clip  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_pre   <= w_pre;
            r_step  <= w_step;
            r_duty  <= w_duty;
            r_pwm   <= (w_state != IDLE) && (w_step < w_duty);
            r_ps    <= w_ps;
            r_clip  <= (w_latch && w_over) || (r_clip && !bus.clip_clr);
        end
    end
    assign bus.pwm_out      = r_pwm;
    assign bus.period_start = r_ps;
    assign bus.busy         = r_state != IDLE;
    assign bus.clip_flag    = r_clip;
endmodule

// File: tb/tb_voice_pwm_dac.sv
// tb_voice_pwm_dac: period-level vector table, directed corner sequences and random
// stimulus against a cycle-position reference model, on a PRESCALE=4 and a PRESCALE=1 instance
module tb_voice_pwm_dac;
    localparam int PRE = 4, MX = 5, PER = PRE * MX;
    localparam int PRE1 = 1, MX1 = 3;
    typedef struct {bit act; bit drain; bit ps; bit clip; int cyc; int duty;} model_t;
    typedef struct {logic [3:0] sum; bit clr; int hi; bit clip;} vec_t;
    logic   clk = 1'b0;
    logic   rst_n = 1'b1;
    int     checks = 0, errors = 0;
    bit     run = 1'b0;
    model_t m0, m1;
    vec_t   tab [10];
    voice_pwm_dac_if #(.SUM_W(4)) b0 ();
    voice_pwm_dac_if #(.SUM_W(4)) b1 ();
    voice_pwm_dac #(.SUM_W(4), .MAX_SUM(MX), .PRESCALE(PRE)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
    voice_pwm_dac #(.SUM_W(4), .MAX_SUM(MX1), .PRESCALE(PRE1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
    assign b1.en       = b0.en;
    assign b1.sum_in   = b0.sum_in;
    assign b1.clip_clr = b0.clip_clr;
    always #5 clk = ~clk;
    // model tracks the absolute cycle position inside the period; slot = cyc / pre
    function automatic model_t nxt(model_t m, bit e, int s, bit c, int pre, int mx);
        model_t n;
        bit     latch;
        n = m;
        latch = 1'b0;
        n.ps = 1'b0;
        if (!m.act) begin
            if (e) begin
                n.act = 1'b1; n.drain = 1'b0; n.cyc = 0; latch = 1'b1;
            end
        end else if (m.cyc == pre * mx - 1) begin
            n.cyc = 0;
            if (!m.drain || e) begin
                latch = 1'b1; n.drain = !e;
            end else begin
                n.act = 1'b0; n.drain = 1'b0; n.duty = 0;
            end
        end else begin
            n.cyc = m.cyc + 1; n.drain = !e;
        end
        if (latch) begin
            n.duty = (s > mx) ? mx : s; n.ps = 1'b1;
        end
        n.clip = (latch && s > mx) ? 1'b1 : (c ? 1'b0 : m.clip);
        return n;
    endfunction
    function automatic bit pwm_of(model_t m, int pre);
        return m.act && (m.cyc / pre < m.duty);
    endfunction
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m0 <= '{default: 0};
            m1 <= '{default: 0};
        end else begin
            m0 <= nxt(m0, b0.en, int'(b0.sum_in), b0.clip_clr, PRE, MX);
            m1 <= nxt(m1, b0.en, int'(b0.sum_in), b0.clip_clr, PRE1, MX1);
        end
    end
    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask
    task automatic chki(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    always @(negedge clk) begin
        if (run) begin
            chk("d0 pwm", b0.pwm_out, pwm_of(m0, PRE));
            chk("d0 period_start", b0.period_start, m0.ps);
            chk("d0 busy", b0.busy, m0.act);
            chk("d0 clip", b0.clip_flag, m0.clip);
            chk("d1 pwm", b1.pwm_out, pwm_of(m1, PRE1));
            chk("d1 period_start", b1.period_start, m1.ps);
            chk("d1 busy", b1.busy, m1.act);
            chk("d1 clip", b1.clip_flag, m1.clip);
        end
    end
    initial begin
        int hi;
        tab[0] = '{4'd3, 1'b0, 12, 1'b0};
        tab[1] = '{4'd3, 1'b0, 12, 1'b0};
        tab[2] = '{4'd0, 1'b0, 0,  1'b0};
        tab[3] = '{4'd5, 1'b0, 20, 1'b0};
        tab[4] = '{4'd5, 1'b0, 20, 1'b0};
        tab[5] = '{4'd9, 1'b0, 20, 1'b1};
        tab[6] = '{4'd2, 1'b0, 8,  1'b1};
        tab[7] = '{4'd2, 1'b1, 8,  1'b0};
        tab[8] = '{4'd1, 1'b0, 4,  1'b0};
        tab[9] = '{4'd4, 1'b0, 16, 1'b0};
        b0.en = 1'b0; b0.sum_in = '0; b0.clip_clr = 1'b0;
        #2 rst_n = 1'b0;
        #10;
        chk("reset pwm", b0.pwm_out, 1'b0);
        chk("reset period_start", b0.period_start, 1'b0);
        chk("reset busy", b0.busy, 1'b0);
        chk("reset clip", b0.clip_flag, 1'b0);
        #4 rst_n = 1'b1;
        run = 1'b1;
        tick();
        chk("idle busy", b0.busy, 1'b0);
        b0.en = 1'b1; b0.sum_in = tab[0].sum;
        tick();
        // each entry is one full period; the next sum is staged mid-period at cycle 5
        for (int i = 0; i < 10; i++) begin
            hi = 0;
            for (int c = 0; c < PER; c++) begin
                if (c == 0) chk("tab period_start", b0.period_start, 1'b1);
                if (c == 5) b0.sum_in = tab[(i + 1) % 10].sum;
                b0.clip_clr = tab[i].clr && c == 10;
                hi += int'(b0.pwm_out);
                if (c == PER - 1) chk("tab clip", b0.clip_flag, tab[i].clip);
                tick();
            end
            chki("tab high cycles", hi, tab[i].hi);
        end
        repeat (PER - 1) tick();
        b0.sum_in = 4'd9; b0.clip_clr = 1'b1;
        tick();
        chk("clip set beats clear", b0.clip_flag, 1'b1);
        chk("clip edge period_start", b0.period_start, 1'b1);
        b0.clip_clr = 1'b0; b0.sum_in = 4'd3;
        repeat (PER - 1) tick();
        tick();
        hi = 0;
        for (int c = 0; c < PER; c++) begin
            if (c == 7) b0.en = 1'b0;
            hi += int'(b0.pwm_out);
            tick();
        end
        chki("drain high cycles", hi, 12);
        chk("drain exit busy", b0.busy, 1'b0);
        chk("drain exit period_start", b0.period_start, 1'b0);
        chk("drain exit pwm", b0.pwm_out, 1'b0);
        b0.en = 1'b1;
        tick();
        chk("restart period_start", b0.period_start, 1'b1);
        for (int c = 0; c < PER; c++) begin
            if (c == 7) b0.en = 1'b0;
            if (c == 12) b0.en = 1'b1;
            tick();
        end
        chk("resume busy", b0.busy, 1'b1);
        chk("resume period_start", b0.period_start, 1'b1);
        repeat (6) tick();
        chk("pre-reset pwm", b0.pwm_out, 1'b1);
        chk("pre-reset clip", b0.clip_flag, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset pwm", b0.pwm_out, 1'b0);
        chk("async reset busy", b0.busy, 1'b0);
        chk("async reset clip", b0.clip_flag, 1'b0);
        chk("async reset period_start", b0.period_start, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post-reset period_start", b0.period_start, 1'b1);
        chk("post-reset busy", b0.busy, 1'b1);
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 39) == 0) b0.en = ~b0.en;
            b0.sum_in = 4'($urandom_range(0, 15));
            b0.clip_clr = $urandom_range(0, 31) == 0;
            tick();
        end
        run = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
